// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Dual-issue MEM stage with data memory, branch-resolution redirect,
//   operand-forwarding select logic and the MEM/WB pipeline register.
//   Lane 1 is always the program-order older instruction of the pair.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   aluResX_MEM                  ALU result / word address (X = 1, 2)
//   forwardBResX_MEM             store data
//   MemReadEnX_MEM, MemtoRegX_MEM, MemWriteEnX_MEM, RegWriteEnX_MEM,
//   jalX_MEM, takenX_MEM         per-lane controls
//   DestRegX_MEM                 destination register
//   return_addrX_MEM, targetX_MEM  link address, resolved branch target
//   rs1_EX, rt1_EX, rs2_EX, rt2_EX  EX-stage source registers
//   ForwardA_1/B_1/A_2/B_2       operand select codes (0 RF, 1 MEM1, 2 MEM2,
//                                3 WB1, 4 WB2)
//   aluResX_MEM_fwd              value forwarded from MEM
//   correct_en, correction, flush_IFID, flush_IDEX  mispredict redirect
//   regWriteX_WB, jalX_WB, writeRegX_WB, writeDataX_WB, aluResX_WB  MEM/WB
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DEPTH = 256   // power of two; address wraps modulo DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] aluRes1_MEM,
    input  logic [31:0] aluRes2_MEM,
    input  logic [31:0] forwardBRes1_MEM,
    input  logic [31:0] forwardBRes2_MEM,
    input  logic        MemReadEn1_MEM,
    input  logic        MemReadEn2_MEM,
    input  logic        MemtoReg1_MEM,
    input  logic        MemtoReg2_MEM,
    input  logic        MemWriteEn1_MEM,
    input  logic        MemWriteEn2_MEM,
    input  logic        RegWriteEn1_MEM,
    input  logic        RegWriteEn2_MEM,
    input  logic        jal1_MEM,
    input  logic        jal2_MEM,
    input  logic        taken1_MEM,
    input  logic        taken2_MEM,
    input  logic [4:0]  DestReg1_MEM,
    input  logic [4:0]  DestReg2_MEM,
    input  logic [9:0]  return_addr1_MEM,
    input  logic [9:0]  return_addr2_MEM,
    input  logic [9:0]  target1_MEM,
    input  logic [9:0]  target2_MEM,
    input  logic [4:0]  rs1_EX,
    input  logic [4:0]  rt1_EX,
    input  logic [4:0]  rs2_EX,
    input  logic [4:0]  rt2_EX,
    output logic [2:0]  ForwardA_1,
    output logic [2:0]  ForwardB_1,
    output logic [2:0]  ForwardA_2,
    output logic [2:0]  ForwardB_2,
    output logic [31:0] aluRes1_MEM_fwd,
    output logic [31:0] aluRes2_MEM_fwd,
    output logic        correct_en,
    output logic        flush_IFID,
    output logic        flush_IDEX,
    output logic [9:0]  correction,
    output logic        regWrite1_WB,
    output logic        regWrite2_WB,
    output logic        jal1_WB,
    output logic        jal2_WB,
    output logic [4:0]  writeReg1_WB,
    output logic [4:0]  writeReg2_WB,
    output logic [31:0] writeData1_WB,
    output logic [31:0] writeData2_WB,
    output logic [31:0] aluRes1_WB,
    output logic [31:0] aluRes2_WB
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] FWD_RF   = 3'd0;
    localparam logic [2:0] FWD_MEM1 = 3'd1;
    localparam logic [2:0] FWD_MEM2 = 3'd2;
    localparam logic [2:0] FWD_WB1  = 3'd3;
    localparam logic [2:0] FWD_WB2  = 3'd4;

    // A taken branch in the older lane squashes the younger lane.
    logic kill2;
    assign kill2 = taken1_MEM;

    assign correct_en = taken1_MEM | (taken2_MEM & ~kill2);
    assign correction = taken1_MEM ? target1_MEM : target2_MEM;
    assign flush_IFID = correct_en;
    assign flush_IDEX = correct_en;

    // ---------------- data memory ----------------
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic          we2;
    logic [31:0]   load1;
    logic [31:0]   load2;

    assign addr1 = aluRes1_MEM[AW-1:0];
    assign addr2 = aluRes2_MEM[AW-1:0];
    assign we2   = MemWriteEn2_MEM & ~kill2;

    // Lane 2 is written last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (MemWriteEn1_MEM) begin
                data_mem[addr1] <= forwardBRes1_MEM;
            end
            if (we2) begin
                data_mem[addr2] <= forwardBRes2_MEM;
            end
        end
    end

    // Lane 1 sees only committed contents; lane 2 must observe the older
    // lane's same-cycle store, so that store is bypassed.
    assign load1 = data_mem[addr1];
    assign load2 = (MemWriteEn1_MEM && (addr1 == addr2)) ? forwardBRes1_MEM
                                                         : data_mem[addr2];

    // ---------------- MEM-stage forward values ----------------
    assign aluRes1_MEM_fwd = jal1_MEM ? {22'b0, return_addr1_MEM} : aluRes1_MEM;
    assign aluRes2_MEM_fwd = jal2_MEM ? {22'b0, return_addr2_MEM} : aluRes2_MEM;

    // ---------------- MEM/WB register ----------------
    logic        reg_write1_d, reg_write2_d, reg_write1_q, reg_write2_q;
    logic        jal1_d, jal2_d, jal1_q, jal2_q;
    logic [4:0]  write_reg1_d, write_reg2_d, write_reg1_q, write_reg2_q;
    logic [31:0] write_data1_d, write_data2_d, write_data1_q, write_data2_q;
    logic [31:0] alu_res1_q, alu_res2_q;

    assign write_reg1_d  = jal1_MEM ? 5'd31 : DestReg1_MEM;
    assign write_reg2_d  = jal2_MEM ? 5'd31 : DestReg2_MEM;
    assign write_data1_d = MemtoReg1_MEM ? load1 : aluRes1_MEM_fwd;
    assign write_data2_d = MemtoReg2_MEM ? load2 : aluRes2_MEM_fwd;
    // Register 0 is hard-wired; never report a write to it.
    assign reg_write1_d  = RegWriteEn1_MEM & (write_reg1_d != 5'd0);
    assign reg_write2_d  = RegWriteEn2_MEM & ~kill2 & (write_reg2_d != 5'd0);
    assign jal1_d        = jal1_MEM;
    assign jal2_d        = jal2_MEM & ~kill2;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write1_q  <= 1'b0;
            reg_write2_q  <= 1'b0;
            jal1_q        <= 1'b0;
            jal2_q        <= 1'b0;
            write_reg1_q  <= 5'd0;
            write_reg2_q  <= 5'd0;
            write_data1_q <= 32'd0;
            write_data2_q <= 32'd0;
            alu_res1_q    <= 32'd0;
            alu_res2_q    <= 32'd0;
        end else begin
            reg_write1_q  <= reg_write1_d;
            reg_write2_q  <= reg_write2_d;
            jal1_q        <= jal1_d;
            jal2_q        <= jal2_d;
            write_reg1_q  <= write_reg1_d;
            write_reg2_q  <= write_reg2_d;
            write_data1_q <= write_data1_d;
            write_data2_q <= write_data2_d;
            alu_res1_q    <= aluRes1_MEM;
            alu_res2_q    <= aluRes2_MEM;
        end
    end

    assign regWrite1_WB  = reg_write1_q;
    assign regWrite2_WB  = reg_write2_q;
    assign jal1_WB       = jal1_q;
    assign jal2_WB       = jal2_q;
    assign writeReg1_WB  = write_reg1_q;
    assign writeReg2_WB  = write_reg2_q;
    assign writeData1_WB = write_data1_q;
    assign writeData2_WB = write_data2_q;
    assign aluRes1_WB    = alu_res1_q;
    assign aluRes2_WB    = alu_res2_q;

    // ---------------- forwarding select ----------------
    // Loads in MEM have no value yet, so they are not forwarding sources.
    logic mem1_ok, mem2_ok, wb1_ok, wb2_ok;
    assign mem1_ok = RegWriteEn1_MEM & ~MemReadEn1_MEM & (DestReg1_MEM != 5'd0);
    assign mem2_ok = RegWriteEn2_MEM & ~MemReadEn2_MEM & (DestReg2_MEM != 5'd0) & ~kill2;
    assign wb1_ok  = reg_write1_q & (write_reg1_q != 5'd0);
    assign wb2_ok  = reg_write2_q & (write_reg2_q != 5'd0);

    logic [3:0][4:0] src_ex;
    logic [3:0][2:0] fwd_code;
    assign src_ex = {rt2_EX, rs2_EX, rt1_EX, rs1_EX};

    // Youngest producer wins: MEM over WB, and lane 2 over lane 1 in a stage.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fwd
            assign fwd_code[gi] =
                (mem2_ok && (DestReg2_MEM == src_ex[gi])) ? FWD_MEM2 :
                (mem1_ok && (DestReg1_MEM == src_ex[gi])) ? FWD_MEM1 :
                (wb2_ok  && (write_reg2_q == src_ex[gi])) ? FWD_WB2  :
                (wb1_ok  && (write_reg1_q == src_ex[gi])) ? FWD_WB1  :
                                                            FWD_RF;
        end
    endgenerate

    assign ForwardA_1 = fwd_code[0];
    assign ForwardB_1 = fwd_code[1];
    assign ForwardA_2 = fwd_code[2];
    assign ForwardB_2 = fwd_code[3];

endmodule
